// File: rtl/axis2axi_in_sched.sv
// Descriptor scheduler for one axis2axi_in write datapath: queues (addr, len)
// descriptors, programs the start address, gates len words through, waits for drain, reports.
module axis2axi_in_sched #(
  parameter int AXI_ADDR_W   = 32,
  parameter int AXI_DATA_W   = 32,
  parameter int LEN_W        = 16,
  parameter int DESC_DEPTH_W = 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic [AXI_ADDR_W-1:0] desc_addr_i,
  input  logic [LEN_W-1:0]      desc_len_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [AXI_DATA_W-1:0] axis_s_data_i,
  input  logic                  axis_s_valid_i,
  output logic                  axis_s_ready_o,
  output logic [AXI_DATA_W-1:0] axis_m_data_o,
  output logic                  axis_m_valid_o,
  input  logic                  axis_m_ready_i,
  output logic [AXI_ADDR_W-1:0] cfg_addr_o,
  output logic                  cfg_valid_o,
  input  logic                  cfg_ready_i,
  output logic [LEN_W-1:0]      done_len_o,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [15:0]           done_count_o,
  output logic                  busy_o
);

  localparam int DEPTH = 1 << DESC_DEPTH_W;
  localparam logic [DESC_DEPTH_W:0] FULL_CNT = (DESC_DEPTH_W+1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONFIG = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [DEPTH-1:0][AXI_ADDR_W-1:0] qa_q, qa_d;
  logic [DEPTH-1:0][LEN_W-1:0]      ql_q, ql_d;
  logic [DESC_DEPTH_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DESC_DEPTH_W:0]            cnt_q, cnt_d;
  logic [2:0]                       state_q, state_d;
  logic [AXI_ADDR_W-1:0]            addr_q, addr_d;
  logic [LEN_W-1:0]                 len_q, len_d, rem_q, rem_d;
  logic [1:0]                       hold_q, hold_d;
  logic [AXI_DATA_W-1:0]            data_q, data_d;
  logic [15:0]                      done_cnt_q, done_cnt_d;
  logic                             push, pop, m_hs;

  // Ready is purely registered-count based; a push never bypasses to IDLE.
  assign desc_ready_o = !rst_i && (cnt_q != FULL_CNT);
  assign cfg_addr_o   = addr_q;
  assign done_len_o   = len_q;
  assign done_count_o = done_cnt_q;
  assign busy_o       = (state_q != S_IDLE) || (cnt_q != '0);

  always_comb begin
    qa_d       = qa_q;
    ql_d       = ql_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    hold_d     = hold_q;
    data_d     = data_q;
    done_cnt_d = done_cnt_q;

    axis_m_data_o  = data_q;
    axis_m_valid_o = 1'b0;
    axis_s_ready_o = 1'b0;
    cfg_valid_o    = 1'b0;
    done_valid_o   = 1'b0;
    m_hs           = 1'b0;

    push = desc_valid_i && desc_ready_o;
    pop  = (state_q == S_IDLE) && (cnt_q != '0);

    if (push) begin
      qa_d[wr_ptr_q] = {desc_addr_i[AXI_ADDR_W-1:2], 2'b00};
      ql_d[wr_ptr_q] = desc_len_i;
      wr_ptr_d       = wr_ptr_q + DESC_DEPTH_W'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + (DESC_DEPTH_W+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (DESC_DEPTH_W+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          addr_d   = qa_q[rd_ptr_q];
          len_d    = ql_q[rd_ptr_q];
          rem_d    = ql_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + DESC_DEPTH_W'(1);
          state_d  = (ql_q[rd_ptr_q] == '0) ? S_REPORT : S_CONFIG;
        end
      end
      S_CONFIG: begin
        cfg_valid_o = cfg_ready_i;
        if (cfg_ready_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        axis_m_data_o  = axis_s_data_i;
        axis_m_valid_o = axis_s_valid_i;
        axis_s_ready_o = axis_m_ready_i;
        data_d         = axis_s_data_i;
        m_hs           = axis_s_valid_i && axis_m_ready_i;
        if (m_hs) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
            hold_d  = 2'd2;
          end
        end
      end
      S_DRAIN: begin
        // cfg_ready_i lags the FIFO level by a couple of cycles after the last word.
        if (hold_q != 2'd0)   hold_d  = hold_q - 2'd1;
        else if (cfg_ready_i) state_d = S_REPORT;
      end
      S_REPORT: begin
        done_valid_o = 1'b1;
        if (done_ready_i) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qa_q       <= '0;
      ql_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      done_cnt_q <= '0;
    end else if (cke_i) begin
      qa_q       <= qa_d;
      ql_q       <= ql_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: doc/axis2axi_in_sched.md
Name: axis2axi_in_sched

Overview:
Descriptor-driven scheduler that sequences one axis2axi_in write datapath. It queues (address, word-count) descriptors and programs the datapath's start address. It then gates exactly the requested number of stream words into the datapath, waits for the datapath to drain to memory, and posts a completion record. It sits between the upstream AXI-stream source / control CPU and the axis2axi_in config and stream ports.

Parameters:
AXI_ADDR_W, 32, width of descriptor and config addresses
AXI_DATA_W, 32, stream word width (4-byte words only)
LEN_W, 16, width of descriptor word count
DESC_DEPTH_W, 2, log2 of descriptor queue depth (depth 4)

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; when 0 all registers hold
rst_i  in  1  synchronous active-high reset
desc_addr_i  in  AXI_ADDR_W  destination byte address; bits [1:0] forced to 0
desc_len_i  in  LEN_W  transfer length in words
desc_valid_i  in  1  descriptor push request
desc_ready_o  out  1  queue not full
axis_s_data_i  in  AXI_DATA_W  upstream stream data
axis_s_valid_i  in  1  upstream valid
axis_s_ready_o  out  1  upstream ready
axis_m_data_o  out  AXI_DATA_W  to datapath axis_in data
axis_m_valid_o  out  1  to datapath axis_in valid
axis_m_ready_i  in  1  datapath axis_in ready
cfg_addr_o  out  AXI_ADDR_W  to datapath config address
cfg_valid_o  out  1  to datapath config valid
cfg_ready_i  in  1  datapath idle and FIFO empty
done_len_o  out  LEN_W  completed descriptor length
done_valid_o  out  1  completion valid
done_ready_i  in  1  completion accepted
done_count_o  out  16  completed descriptors, wraps at 2^16
busy_o  out  1  state != IDLE or queue non-empty

Behaviour:
- Clocking: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset: state IDLE, queue empty, counters 0. All *_valid_o = 0, axis_s_ready_o = 0, done_len_o = 0, done_count_o = 0, busy_o = 0. desc_ready_o = 0 while rst_i = 1 and 1 afterwards.
- Reset mid-operation: the queue is flushed and all words in flight are dropped. The system resets the datapath with the same rst_i.
- Descriptor queue: register FIFO of depth 2^DESC_DEPTH_W. Push on desc_valid_i & desc_ready_o. desc_ready_o = !full, computed from the registered count, with no same-cycle bypass. A push to an empty queue is visible to IDLE on the next cycle. Push and pop in the same cycle leave the count unchanged.
- State machine:
  - IDLE: if the queue is non-empty, pop into addr_r and len_r. Go to REPORT if the popped len is 0, otherwise go to CONFIG.
  - CONFIG: cfg_addr_o = addr_r. cfg_valid_o = cfg_ready_i, so it is only ever asserted together with ready. Go to STREAM on that cycle.
  - STREAM: combinational pass-through with zero latency: axis_m_data_o = axis_s_data_i, axis_m_valid_o = axis_s_valid_i, axis_s_ready_o = axis_m_ready_i. remaining (LEN_W bits, loaded with len_r) decrements on axis_m_valid_o & axis_m_ready_i. A handshake with remaining = 1 goes to DRAIN.
  - DRAIN: axis_m_valid_o = 0 and axis_s_ready_o = 0. Holding valid low is required so the datapath flushes its final partial burst. A 2-cycle holdoff counter ignores cfg_ready_i while the datapath FIFO level updates. After the holdoff, go to REPORT when cfg_ready_i = 1, which means the burst data and BRESP are complete.
  - REPORT: done_valid_o = 1, done_len_o = len_r, held stable until done_ready_i. On the handshake, done_count_o increments and the state returns to IDLE.
- Outside STREAM: axis_s_ready_o = 0, axis_m_valid_o = 0, and axis_m_data_o holds its last value. Upstream data is never dropped.
- Descriptor throughput: two consecutive descriptors have at least 1 idle cycle between REPORT and the next CONFIG.
- Length arithmetic: modulo-free. The maximum length is 2^LEN_W - 1 words. 4 KB boundary splitting is handled by the datapath, not here.
- Simultaneous events: pushes are accepted in any state while not full. cke_i = 0 freezes the FSM and all counters. Combinational outputs follow the frozen state.

Test Plan:
- Push {0x1000, 4}, stream 4 words, cfg_ready_i drops 1 cycle after the first word and rises 10 cycles after the last → one cfg_valid_o pulse with addr 0x1000; exactly 4 words forwarded; axis_s_ready_o = 0 afterwards; done_len_o = 4 only after cfg_ready_i returns high; done_count_o = 1.
- Push {0x2003, 3} then {0x3000, 0} → cfg_addr_o = 0x2000; the second descriptor yields done_len_o = 0 with no cfg_valid_o and no stream handshakes; done_count_o = 2.
- Push 5 descriptors back-to-back while the FSM is blocked in STREAM → desc_ready_o falls after the 4th push; the 5th is accepted once a pop occurs; all 5 complete in order.
- Upstream valid held high continuously, axis_m_ready_i toggling 1/0, len = 7 → exactly 7 forwarded handshakes; the 8th word stays unaccepted (axis_s_ready_o = 0) until the next descriptor reaches STREAM.
- Hold done_ready_i = 0 for 20 cycles in REPORT → done_valid_o and done_len_o stay stable; the next descriptor is not popped.
- Assert rst_i for 1 cycle mid-STREAM after 2 of 8 words → all outputs take reset values the following cycle; the queue is empty; busy_o = 0; a new descriptor then runs normally.
